// File: rtl/mc_controller_pkg.sv
// Shared FSM state, opcode and datapath select encodings for the multicycle controller.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL,
    ST_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_NOP   = 7'b0000000;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_imm_src_dec.sv
// Immediate-format select decoded purely from the opcode; valid in every FSM state.
module imm_src_dec
  import mc_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V style main controller FSM with a unified-memory handshake.
// Optional ILLEGAL_TRAP_EN: unimplemented opcodes trap into a sticky ILLEGAL state.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t state_q, state_d;

  imm_src_dec u_imm_src_dec (
    .op      (op),
    .imm_src (ImmSrc)
  );

  // Reset is asynchronous so an in-flight memory write is dropped without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    InstrDone = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXECR;
          OP_ITYPE:     state_d = ST_EXECI;
          OP_BEQ:       state_d = ST_BEQ;
          OP_JAL:       state_d = ST_JAL;
          OP_NOP: begin
            state_d   = ST_FETCH;
            InstrDone = 1'b1;
          end
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = ST_ILLEGAL;
`else
          default:      state_d = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = ST_MEMWB;
      end
      ST_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          state_d   = ST_FETCH;
          InstrDone = 1'b1;
        end
      end
      ST_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXECR, ST_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = (state_q == ST_EXECI) ? SRCB_IMM : SRCB_RD2;
        ALUOp   = ALUOP_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BEQ: begin
        ALUSrcA   = SRCA_RD1;
        ALUOp     = ALUOP_SUB;
        PCWrite   = Zero;
        InstrDone = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = ST_ALUWB;
      end
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_FETCH;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign Illegal = (state_q == ST_ILLEGAL);
`else
  assign Illegal = 1'b0;
`endif

endmodule
